hilo_mdu: RTL and testbench



---
 rtl/hilo_mdu.sv | 155 +++++++++++++++
 tb/tb_hilo_mdu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// HI/LO register unit with single-cycle multiply and W-cycle restoring divide.
// Optional macro HILO_FWD_EN forwards MULT/MULTU/MTHI/MTLO write data onto hi_o/lo_o in the issue cycle.
module hilo_mdu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  typedef enum logic {IDLE, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int CW = $clog2(W + 1);

  state_t        state_q;
  logic [W-1:0]  hi_q, lo_q;
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          qNeg_q, rNeg_q, divZero_q, done_q;

  logic           issue, isDiv, isSigned;
  logic [2*W-1:0] prodS, prodU, prod;
  logic [W-1:0]   aMag, bMag;
  logic [W-1:0]   remIn, quoIn, dvsIn;
  logic [W:0]     remShift;
  logic [W+1:0]   diff;
  logic           subOk;
  logic [W-1:0]   remNext, quoNext, qRes, rRes;
  logic           unusedBits;

  assign issue    = (state_q == IDLE) & start & ~flush;
  assign isDiv    = (op == OP_DIV) | (op == OP_DIVU);
  assign isSigned = (op == OP_DIV);

  assign prodS = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
  assign prodU = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign prod  = (op == OP_MULT) ? prodS : prodU;

  // Negation in W bits yields the correct unsigned magnitude even for the most-negative value.
  assign aMag = (isSigned & a[W-1]) ? ('0 - a) : a;
  assign bMag = (isSigned & b[W-1]) ? ('0 - b) : b;

  // One restoring step; the issue cycle performs the first step straight from the operands.
  assign remIn    = issue ? '0 : rem_q;
  assign quoIn    = issue ? aMag : quo_q;
  assign dvsIn    = issue ? bMag : dvs_q;
  assign remShift = {remIn, quoIn[W-1]};
  assign diff     = {1'b0, remShift} - {2'b00, dvsIn};
  assign subOk    = ~diff[W+1];
  assign remNext  = subOk ? diff[W-1:0] : remShift[W-1:0];
  assign quoNext  = {quoIn[W-2:0], subOk};
  assign unusedBits = diff[W];

  assign qRes = qNeg_q ? ('0 - quoNext) : quoNext;
  assign rRes = rNeg_q ? ('0 - remNext) : remNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qNeg_q    <= 1'b0;
      rNeg_q    <= 1'b0;
      divZero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            case (op)
              OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod;
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              OP_DIV, OP_DIVU: begin
                rem_q     <= remNext;
                quo_q     <= quoNext;
                dvs_q     <= bMag;
                qNeg_q    <= isSigned & (a[W-1] ^ b[W-1]);
                rNeg_q    <= isSigned & a[W-1];
                divZero_q <= (b == '0);
                cnt_q     <= CW'(W);
                state_q   <= DIV;
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            rem_q <= remNext;
            quo_q <= quoNext;
            cnt_q <= cnt_q - 1'b1;
            // Counter stepping down to 1 marks the final step of W.
            if (cnt_q == CW'(2)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              if (!divZero_q) begin
                hi_q <= rRes;
                lo_q <= qRes;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == DIV) | (issue & isDiv);
  assign done = done_q;

`ifdef HILO_FWD_EN
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (issue) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          hi_o = prod[2*W-1:W];
          lo_o = prod[W-1:0];
        end
        OP_MTHI: hi_o = a;
        OP_MTLO: lo_o = a;
        default: ;
      endcase
    end
  end
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed testbench for hilo_mdu: reset, MTHI/MTLO, multiply, divide edge cases, flush and forwarding.
module tb_hilo_mdu;

  localparam int W = 32;

  logic         clk, rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi_o, lo_o;

  int checkCount = 0;
  int passCount  = 0;

  hilo_mdu #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide and watches a fixed window; entry and exit are just after a rising edge.
  task automatic doDiv(input logic [2:0] dOp, input logic [W-1:0] dA, input logic [W-1:0] dB,
                       output int busyCount, output int doneCycle, output int doneCount,
                       output logic busyAtDone, output logic [W-1:0] hiSeen, output logic [W-1:0] loSeen);
    busyCount = 0; doneCycle = -1; doneCount = 0; busyAtDone = 1'bx; hiSeen = 'x; loSeen = 'x;
    start = 1'b1; op = dOp; a = dA; b = dB;
    @(negedge clk);
    if (busy) busyCount++;
    nextCycle();
    start = 1'b0;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = k; busyAtDone = busy; hiSeen = hi_o; loSeen = lo_o;
        end
      end
      if (busy) busyCount++;
      nextCycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkCount++; if (hi_o !== '0) $display("[TB] FAIL reset_hi: got %h expected 0", hi_o); else passCount++;
    checkCount++; if (lo_o !== '0) $display("[TB] FAIL reset_lo: got %h expected 0", lo_o); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
    nextCycle();
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    nextCycle();
    op = 3'd5; a = 32'hDEAD_BEEF;
    @(negedge clk);
    checkCount++; if (hi_o !== 32'h1234_5678) $display("[TB] FAIL mthi: got %h expected 12345678", hi_o); else passCount++;
    nextCycle();
    start = 1'b0;
    @(negedge clk);
    checkCount++; if (lo_o !== 32'hDEAD_BEEF) $display("[TB] FAIL mtlo: got %h expected deadbeef", lo_o); else passCount++;
    checkCount++; if (hi_o !== 32'h1234_5678) $display("[TB] FAIL mtlo_keeps_hi: got %h expected 12345678", hi_o); else passCount++;
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkCount++; if (hi_o !== '0) $display("[TB] FAIL midreset_hi: got %h expected 0", hi_o); else passCount++;
    checkCount++; if (lo_o !== '0) $display("[TB] FAIL midreset_lo: got %h expected 0", lo_o); else passCount++;
    nextCycle();
  endtask

  task automatic test_mult();
    logic [W-1:0] expB2b;
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk);
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL mult_busy: got %b expected 0", busy); else passCount++;
    nextCycle();
    start = 1'b0;
    @(negedge clk);
    checkCount++; if (hi_o !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi_o); else passCount++;
    checkCount++; if (lo_o !== 32'hFFFF_FFEB) $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo_o); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL mult_done: got %b expected 0", done); else passCount++;
    nextCycle();
    start = 1'b1; op = 3'd1;
    nextCycle();
    start = 1'b0;
    @(negedge clk);
    checkCount++; if (hi_o !== 32'h0000_0006) $display("[TB] FAIL multu_hi: got %h expected 00000006", hi_o); else passCount++;
    checkCount++; if (lo_o !== 32'hFFFF_FFEB) $display("[TB] FAIL multu_lo: got %h expected ffffffeb", lo_o); else passCount++;
    nextCycle();
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    nextCycle();
    a = 32'd5; b = 32'd6;
`ifdef HILO_FWD_EN
    expB2b = 32'd30;
`else
    expB2b = 32'd12;
`endif
    @(negedge clk);
    checkCount++; if (lo_o !== expB2b) $display("[TB] FAIL b2b_first: got %h expected %h", lo_o, expB2b); else passCount++;
    nextCycle();
    start = 1'b0;
    @(negedge clk);
    checkCount++; if (lo_o !== 32'd30) $display("[TB] FAIL b2b_second_lo: got %h expected 0000001e", lo_o); else passCount++;
    checkCount++; if (hi_o !== 32'd0) $display("[TB] FAIL b2b_second_hi: got %h expected 0", hi_o); else passCount++;
    nextCycle();
  endtask

  task automatic test_div();
    int bc, dc, dn;
    logic bd;
    logic [W-1:0] hs, ls;
    doDiv(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc, dn, bd, hs, ls);
    checkCount++; if (bc != 32) $display("[TB] FAIL div_busy_cycles: got %0d expected 32", bc); else passCount++;
    checkCount++; if (dc != 32) $display("[TB] FAIL div_done_cycle: got %0d expected 32", dc); else passCount++;
    checkCount++; if (dn != 1) $display("[TB] FAIL div_done_pulses: got %0d expected 1", dn); else passCount++;
    checkCount++; if (bd !== 1'b0) $display("[TB] FAIL div_busy_at_done: got %b expected 0", bd); else passCount++;
    checkCount++; if (ls !== 32'hFFFF_FFFD) $display("[TB] FAIL div_lo: got %h expected fffffffd", ls); else passCount++;
    checkCount++; if (hs !== 32'hFFFF_FFFF) $display("[TB] FAIL div_hi: got %h expected ffffffff", hs); else passCount++;
    doDiv(3'd3, 32'd7, 32'd2, bc, dc, dn, bd, hs, ls);
    checkCount++; if (dc != 32) $display("[TB] FAIL divu_done_cycle: got %0d expected 32", dc); else passCount++;
    checkCount++; if (ls !== 32'd3) $display("[TB] FAIL divu_lo: got %h expected 3", ls); else passCount++;
    checkCount++; if (hs !== 32'd1) $display("[TB] FAIL divu_hi: got %h expected 1", hs); else passCount++;
  endtask

  task automatic test_div_edge();
    int bc, dc, dn;
    logic bd;
    logic [W-1:0] hs, ls;
    doDiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, dn, bd, hs, ls);
    checkCount++; if (ls !== 32'h8000_0000) $display("[TB] FAIL divmin_lo: got %h expected 80000000", ls); else passCount++;
    checkCount++; if (hs !== 32'd0) $display("[TB] FAIL divmin_hi: got %h expected 0", hs); else passCount++;
    start = 1'b1; op = 3'd4; a = 32'd5;
    nextCycle();
    op = 3'd5; a = 32'd9;
    nextCycle();
    start = 1'b0;
    nextCycle();
    doDiv(3'd2, 32'd123, 32'd0, bc, dc, dn, bd, hs, ls);
    checkCount++; if (dc != 32) $display("[TB] FAIL divzero_done_cycle: got %0d expected 32", dc); else passCount++;
    checkCount++; if (dn != 1) $display("[TB] FAIL divzero_done_pulses: got %0d expected 1", dn); else passCount++;
    checkCount++; if (hs !== 32'd5) $display("[TB] FAIL divzero_hi: got %h expected 5", hs); else passCount++;
    checkCount++; if (ls !== 32'd9) $display("[TB] FAIL divzero_lo: got %h expected 9", ls); else passCount++;
  endtask

  task automatic test_flush();
    int doneSeen = 0;
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    nextCycle();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      flush = (k == 10);
      @(negedge clk);
      if (done) doneSeen++;
      if (k == 10) begin
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL flush_busy_c10: got %b expected 1", busy); else passCount++;
      end
      if (k == 11) begin
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy_c11: got %b expected 0", busy); else passCount++;
      end
      nextCycle();
    end
    flush = 1'b0;
    checkCount++; if (doneSeen != 0) $display("[TB] FAIL flush_done: got %0d pulses expected 0", doneSeen); else passCount++;
    @(negedge clk);
    checkCount++; if (hi_o !== 32'd5) $display("[TB] FAIL flush_hi: got %h expected 5", hi_o); else passCount++;
    checkCount++; if (lo_o !== 32'd9) $display("[TB] FAIL flush_lo: got %h expected 9", lo_o); else passCount++;
    nextCycle();
  endtask

  task automatic test_start_during_div();
    int doneCycle = -1;
    logic [W-1:0] hs = 'x, ls = 'x;
    start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd2;
    nextCycle();
    start = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      start = (k == 5);
      op = (k == 5) ? 3'd0 : 3'd3;
      a = (k == 5) ? 32'd3 : 32'd7;
      b = (k == 5) ? 32'd3 : 32'd2;
      @(negedge clk);
      if (k == 6) begin
        checkCount++; if (lo_o !== 32'd9) $display("[TB] FAIL ignored_mult_lo: got %h expected 9", lo_o); else passCount++;
      end
      if (done && doneCycle < 0) begin
        doneCycle = k; hs = hi_o; ls = lo_o;
      end
      nextCycle();
    end
    start = 1'b0;
    checkCount++; if (doneCycle != 32) $display("[TB] FAIL ignored_done_cycle: got %0d expected 32", doneCycle); else passCount++;
    checkCount++; if (ls !== 32'd3) $display("[TB] FAIL ignored_div_lo: got %h expected 3", ls); else passCount++;
    checkCount++; if (hs !== 32'd1) $display("[TB] FAIL ignored_div_hi: got %h expected 1", hs); else passCount++;
  endtask

  task automatic test_forward();
    logic [W-1:0] expLo0, expHi0;
`ifdef HILO_FWD_EN
    expLo0 = 32'hA5A5_A5A5;
    expHi0 = 32'hFFFF_FFFF;
`else
    expLo0 = 32'd3;
    expHi0 = 32'd1;
`endif
    start = 1'b1; op = 3'd5; a = 32'hA5A5_A5A5;
    @(negedge clk);
    checkCount++; if (lo_o !== expLo0) $display("[TB] FAIL fwd_mtlo_c0: got %h expected %h", lo_o, expLo0); else passCount++;
    nextCycle();
    start = 1'b0;
    @(negedge clk);
    checkCount++; if (lo_o !== 32'hA5A5_A5A5) $display("[TB] FAIL fwd_mtlo_c1: got %h expected a5a5a5a5", lo_o); else passCount++;
    nextCycle();
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk);
    checkCount++; if (hi_o !== expHi0) $display("[TB] FAIL fwd_mult_c0: got %h expected %h", hi_o, expHi0); else passCount++;
    nextCycle();
    start = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd7; a = '0; b = '0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_edge();
    test_flush();
    test_start_during_div();
    test_forward();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
